// File: rtl/fila_entrada_tarefas_pkg.sv
// rtl/fila_entrada_tarefas_pkg.sv - shared definitions for the job input queue
//
// Purpose : FSM state encoding of the issue sequencer and the latency of the
//           attached control FSM (start cycle to valid strobe).
package fila_entrada_tarefas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } estado_t;

    // Cycles from the control FSM's start cycle to its valid strobe.
    localparam int CTRL_LAT = 7;

endpackage

// File: rtl/fila_circular.sv
// rtl/fila_circular.sv - parameterised circular FIFO
//
// Purpose : circular buffer of DEPTH entries of WIDTH bits.
// Ports   : clock, reset (sync, active-high)
//           push, wr_data    - write side; ignored while full
//           pop              - read side; ignored while empty
//           head             - entry at the read pointer
//           count            - occupancy, 0..DEPTH
//           full, empty      - occupancy flags
// DEPTH must be a power of two and at least 2, so that the pointers wrap
// naturally at their bit width.
module fila_circular #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage carries no reset: contents are only read once counted in.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fila_entrada_tarefas.sv
// rtl/fila_entrada_tarefas.sv - operand queue and job issuer for bloco_controle
//
// Purpose : buffers X operands, issues one start pulse per job to the control
//           FSM, holds X for the whole job and captures the result S.
// Ports   : clock, reset (sync, active-high, shared with the control FSM)
//           in_data/in_valid/in_ready      - operand input handshake
//           x_out                          - operand to the datapath X register
//           start                          - one-cycle job request
//           ctrl_ready, ctrl_valid, s_in   - control FSM status and result
//           out_data/out_valid/out_ready   - result output handshake
//           count                          - FIFO occupancy
//           busy                           - job in flight (ISSUE or WAIT)
module fila_entrada_tarefas
    import fila_entrada_tarefas_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         x_out,
    output logic                     start,
    input  logic                     ctrl_ready,
    input  logic                     ctrl_valid,
    input  logic [WIDTH-1:0]         s_in,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    estado_t          state;
    estado_t          state_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             issue;
    logic [WIDTH-1:0] head;

    // in_ready looks only at occupancy, so a full FIFO refuses a push even in
    // the cycle a job is popped.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    // A job is issued only with the output register empty, so an undelivered
    // result can never be overwritten.
    assign issue = (state == ST_IDLE) && !fifo_empty && ctrl_ready && !out_valid;

    fila_circular #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fila (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .wr_data (in_data),
        .pop     (issue),
        .head    (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ctrl_valid outside WAIT is a protocol error and is simply ignored.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (issue) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (ctrl_valid) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign start = (state == ST_ISSUE);
    assign busy  = (state == ST_ISSUE) || (state == ST_WAIT);

    // x_out moves only on the issue edge, so it stays stable through the
    // control FSM's load cycle and the whole job.
    always_ff @(posedge clock) begin
        if (reset) begin
            x_out <= '0;
        end else if (issue) begin
            x_out <= head;
        end
    end

    // Capture takes priority over delivery.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if ((state == ST_WAIT) && ctrl_valid) begin
            out_data  <= s_in;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fila_entrada_tarefas.sv
// tb/tb_fila_entrada_tarefas.sv - directed bench for fila_entrada_tarefas
module tb_fila_entrada_tarefas;
    import fila_entrada_tarefas_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x_out;
    logic             start;
    logic             ctrl_ready;
    logic             ctrl_valid;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       count;
    logic             busy;

    // Control FSM stand-in: idle when cnt==0, valid CTRL_LAT cycles after start.
    logic [3:0]       cnt;
    logic             ctrl_en;
    logic             force_valid;

    int vectors;
    int miscompares;

    fila_entrada_tarefas #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x_out      (x_out),
        .start      (start),
        .ctrl_ready (ctrl_ready),
        .ctrl_valid (ctrl_valid),
        .s_in       (s_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            if (start) cnt <= 4'd1;
        end else if (cnt == 4'(CTRL_LAT)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    assign ctrl_ready = ctrl_en && (cnt == '0);
    assign ctrl_valid = (cnt == 4'(CTRL_LAT)) || force_valid;
    assign s_in       = x_out + 16'd1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_result(input string tag, input logic [WIDTH-1:0] expected);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_seen"}, 32'(out_valid), 32'd1);
        check(tag, 32'(out_data), 32'(expected));
        @(negedge clock);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_start"},     32'(start),     32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_count"},     32'(count),     32'd0);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_x_out"},     32'(x_out),     32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        ctrl_en     = 1'b1;
        force_valid = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_state("reset");

        // Single job: X=3 -> S=4
        reset    = 1'b0;
        in_data  = 16'd3;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        check("single_count_after_push", 32'(count), 32'd1);
        check("single_start_idle", 32'(start), 32'd0);
        @(negedge clock);
        check("single_start_high", 32'(start), 32'd1);
        check("single_busy_issue", 32'(busy), 32'd1);
        check("single_x_out_issue", 32'(x_out), 32'd3);
        check("single_count_popped", 32'(count), 32'd0);
        @(negedge clock);
        check("single_start_one_cycle", 32'(start), 32'd0);
        check("single_busy_wait", 32'(busy), 32'd1);
        n = 0;
        while (!ctrl_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("single_ctrl_valid_seen", 32'(ctrl_valid), 32'd1);
        check("single_x_out_held", 32'(x_out), 32'd3);
        check("single_out_valid_pre", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out_data", 32'(out_data), 32'd4);
        check("single_busy_done", 32'(busy), 32'd0);
        @(negedge clock);
        check("single_out_valid_cleared", 32'(out_valid), 32'd0);

        // Fill and back-pressure: push 1..5 with the control FSM held busy
        ctrl_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_data  = 16'(i);
            in_valid = 1'b1;
            @(negedge clock);
            if (i == 4) begin
                check("fill_count_4", 32'(count), 32'd4);
                check("fill_in_ready_low", 32'(in_ready), 32'd0);
            end
        end
        in_valid = 1'b0;
        check("fill_count_after_5th", 32'(count), 32'd4);
        ctrl_en = 1'b1;
        wait_result("fill_r1", 16'd2);
        wait_result("fill_r2", 16'd3);
        wait_result("fill_r3", 16'd4);
        wait_result("fill_r4", 16'd5);
        check("fill_drained", 32'(count), 32'd0);

        // Output stall: no new start while a result is undelivered
        in_data  = 16'd10;
        in_valid = 1'b1;
        @(negedge clock);
        in_data  = 16'd20;
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_result("stall_r1", 16'd11);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (start) seen = 1;
            @(negedge clock);
        end
        check("stall_no_start", 32'(seen), 32'd0);
        check("stall_out_valid_held", 32'(out_valid), 32'd1);
        check("stall_out_data_held", 32'(out_data), 32'd11);
        check("stall_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            if (start) seen = 1;
        end
        check("stall_start_within_2", 32'(seen), 32'd1);
        wait_result("stall_r2", 16'd21);

        // Full with simultaneous pop: push refused in the issue cycle
        ctrl_en = 1'b0;
        for (int i = 30; i <= 33; i++) begin
            in_data  = 16'(i);
            in_valid = 1'b1;
            @(negedge clock);
        end
        check("fullpop_count_4", 32'(count), 32'd4);
        in_data = 16'd34;
        ctrl_en = 1'b1;
        check("fullpop_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clock);
        in_valid = 1'b0;
        check("fullpop_count_3", 32'(count), 32'd3);
        check("fullpop_start", 32'(start), 32'd1);
        wait_result("fullpop_r1", 16'd31);
        wait_result("fullpop_r2", 16'd32);
        wait_result("fullpop_r3", 16'd33);
        wait_result("fullpop_r4", 16'd34);
        repeat (15) @(negedge clock);
        check("fullpop_no_extra_valid", 32'(out_valid), 32'd0);
        check("fullpop_no_extra_busy", 32'(busy), 32'd0);
        check("fullpop_count_0", 32'(count), 32'd0);

        // Wrap-around: ten sequential jobs
        for (int i = 0; i < 10; i++) begin
            in_data  = 16'(i);
            in_valid = 1'b1;
            @(negedge clock);
            in_valid = 1'b0;
            wait_result($sformatf("wrap_r%0d", i), 16'(i + 1));
        end
        check("wrap_count_0", 32'(count), 32'd0);

        // Reset mid-job, then a stray ctrl_valid in IDLE
        in_data  = 16'd50;
        in_valid = 1'b1;
        @(negedge clock);
        in_data  = 16'd60;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("midreset_busy_before", 32'(busy), 32'd1);
        check("midreset_count_before", 32'(count), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_state("midreset");
        reset       = 1'b0;
        force_valid = 1'b1;
        @(negedge clock);
        force_valid = 1'b0;
        check("stray_valid_busy", 32'(busy), 32'd0);
        @(negedge clock);
        check("stray_valid_out_valid", 32'(out_valid), 32'd0);
        check("stray_valid_out_data", 32'(out_data), 32'd0);
        repeat (5) @(negedge clock);
        check("stray_valid_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
